// File: rtl/test_port_pkg.sv
// Shared types and constants for the test-port write path.
package test_port_pkg;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [ADDR_W-1:0] TEST_PORT_ADDR = 30'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/tp_fifo.sv
// Small synchronous FIFO with registered ready/empty flags derived from next-state occupancy.
module tp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         ready,
    output logic         empty,
    output logic         nonempty_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_s;
    logic             ready_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // Guard against push-when-full and pop-when-empty from the caller.
    assign push_s = push & ready_r;
    assign pop_s  = pop & ~empty_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + (PTR_W + 1)'(1);
            2'b01:   count_s = count_r - (PTR_W + 1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            ready_r  <= 1'b1;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_s;
            ready_r <= (count_s != FULL_LVL);
            empty_r <= (count_s == {(PTR_W + 1){1'b0}});
        end
    end

    assign rdata         = mem_r[rd_ptr_r];
    assign ready         = ready_r;
    assign empty         = empty_r;
    assign nonempty_next = (count_s != {(PTR_W + 1){1'b0}});

endmodule

// File: rtl/test_port_writer.sv
// Replays buffered result words as single edge-countable memory writes toward the checker.
module test_port_writer
    import test_port_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [29:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    input  logic              mem_stall,
    output logic [29:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  sent_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t              state_r;
    state_t              state_s;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_s;
    logic                pop_s;
    logic                accept_s;
    logic                fifo_ready_s;
    logic                fifo_empty_s;
    logic                fifo_nonempty_next_s;
    logic [ENTRY_W-1:0]  fifo_rdata_s;
    entry_t              head_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                mem_wen_r;
    logic                busy_r;
    logic                overflow_r;
    logic [CNT_W-1:0]    sent_r;

    tp_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (in_valid & fifo_ready_s),
        .pop           (pop_s),
        .wdata         ({in_addr, in_data}),
        .rdata         (fifo_rdata_s),
        .ready         (fifo_ready_s),
        .empty         (fifo_empty_s),
        .nonempty_next (fifo_nonempty_next_s)
    );

    assign head_s = fifo_rdata_s;

    // Write sequencing; leaving GAP can issue the next word directly.
    always_comb begin
        state_s   = state_r;
        gap_cnt_s = gap_cnt_r;
        pop_s     = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (!mem_stall) begin
                    accept_s  = 1'b1;
                    gap_cnt_s = GAP_LOAD;
                    state_s   = GAP;
                end else begin
                    state_s = WRITE;
                end
            end
            GAP: begin
                if (gap_cnt_r != GAP_W'(0)) begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, registered memory-side outputs and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            gap_cnt_r   <= {GAP_W{1'b0}};
            mem_addr_r  <= TEST_PORT_ADDR;
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wen_r   <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            sent_r      <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            mem_wen_r <= (state_s == WRITE);
            if (pop_s) begin
                mem_addr_r  <= head_s.addr;
                mem_wdata_r <= head_s.data;
            end
            if (accept_s) begin
                sent_r <= sent_r + CNT_W'(1);
            end
            if (in_valid && !fifo_ready_s) begin
                overflow_r <= 1'b1;
            end
            busy_r <= (state_s != IDLE) | fifo_nonempty_next_s;
        end
    end

    assign in_ready   = fifo_ready_s;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wen    = mem_wen_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign sent_count = sent_r;

endmodule

// File: tb/tb_test_port_writer.sv
// Scoreboard bench for test_port_writer: expected writes queued at push, compared as the DUT issues them.
module tb_test_port_writer;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [29:0] in_addr;
    logic [31:0] in_data;
    logic        mem_stall;
    logic        in_ready, mem_wen, busy, overflow;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] sent_count;
    logic        in_ready_b, mem_wen_b, busy_b, overflow_b;
    logic [29:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [1:0]  sent_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         sb_q[$];
    logic [15:0] exp_sent = 16'd0;
    logic        prev_acc = 1'b0;
    logic        drv_exp_ready = 1'b0;
    int          wen_cycles = 0;
    logic [1:0]  seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    test_port_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready), .mem_stall(mem_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .busy(busy), .overflow(overflow), .sent_count(sent_count)
    );

    test_port_writer #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready_b), .mem_stall(mem_stall), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_wen(mem_wen_b), .busy(busy_b), .overflow(overflow_b), .sent_count(sent_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares presented writes with the queue head, predicts acceptance, records pushes.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            sb_q.delete();
            exp_sent = 16'd0;
            prev_acc = 1'b0;
        end else begin
            check_val("sent_count", {48'd0, sent_count}, {48'd0, exp_sent});
            check_val("sent_count_w2", {62'd0, sent_b}, {62'd0, exp_sent[1:0]});
            if (prev_acc) check_val("gap_low", {63'd0, mem_wen}, 64'd0);
            prev_acc = 1'b0;
            if (mem_wen) begin
                wen_cycles++;
                check_val("wen_has_expect", {63'd0, sb_q.size() != 0}, 64'd1);
                if (sb_q.size() != 0) begin
                    check_val("addr", {34'd0, mem_addr}, {34'd0, sb_q[0].addr});
                    check_val("data", {32'd0, mem_wdata}, {32'd0, sb_q[0].data});
                    if (!mem_stall) begin
                        void'(sb_q.pop_front());
                        exp_sent = exp_sent + 16'd1;
                        prev_acc = 1'b1;
                    end
                end
            end
            if (in_valid && drv_exp_ready) sb_q.push_back({in_addr, in_data});
        end
    end

    // Called at posedge+1; holds the word for one edge.
    task automatic push_word(input logic [29:0] a, input logic [31:0] d, input logic exp_rdy);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        drv_exp_ready = exp_rdy;
        check_val("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drv_exp_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        check_val("drain_done", {63'd0, (sb_q.size() == 0) && !busy}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_wen"}, {63'd0, mem_wen}, 64'd0);
        check_val({tag, "_addr"}, {34'd0, mem_addr}, 64'd0);
        check_val({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        check_val({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        check_val({tag, "_sent"}, {48'd0, sent_count}, 64'd0);
    endtask

    initial begin
        int wc;
        clk = 1'b0; rst = 1'b0; in_valid = 1'b0; in_addr = 30'd0; in_data = 32'd0; mem_stall = 1'b0;
        #12;
        check_reset_values("rst0");
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // 1: single write, no stall
        push_word(30'd0, 32'd90, 1'b1);
        @(posedge clk); #1;
        check_val("t1_wen", {63'd0, mem_wen}, 64'd1);
        check_val("t1_data", {32'd0, mem_wdata}, 64'd90);
        @(posedge clk); #1;
        check_val("t1_wen_low", {63'd0, mem_wen}, 64'd0);
        check_val("t1_sent", {48'd0, sent_count}, 64'd1);
        check_val("t1_busy_gap", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        check_val("t1_busy_idle", {63'd0, busy}, 64'd0);

        // 2: write held by a 5-cycle stall
        mem_stall = 1'b1;
        wc = wen_cycles;
        push_word(30'd0, 32'd7, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_val("t2_sent_stalled", {48'd0, sent_count}, 64'd1);
        mem_stall = 1'b0;
        @(posedge clk); #1;
        check_val("t2_sent", {48'd0, sent_count}, 64'd2);
        check_val("t2_wen_cycles", 64'(wen_cycles - wc), 64'd6);

        // 3: back-to-back pushes
        push_word(30'd0, 32'd1, 1'b1);
        push_word(30'd0, 32'd2, 1'b1);
        push_word(30'd0, 32'd3, 1'b1);
        drain();
        check_val("t3_sent", {48'd0, sent_count}, 64'd5);

        // 4: fill under stall, then overflow
        mem_stall = 1'b1;
        for (int i = 0; i < 5; i++) push_word(30'h100 + 30'(i), 32'hA0 + 32'(i), 1'b1);
        check_val("t4_ready_low", {63'd0, in_ready}, 64'd0);
        check_val("t4_ovf_before", {63'd0, overflow}, 64'd0);
        push_word(30'h1FF, 32'hDEAD, 1'b0);
        check_val("t4_ovf_set", {63'd0, overflow}, 64'd1);
        check_val("t4_busy", {63'd0, busy}, 64'd1);
        mem_stall = 1'b0;
        drain();
        check_val("t4_ovf_sticky", {63'd0, overflow}, 64'd1);
        check_val("t4_sent", {48'd0, sent_count}, 64'd10);
        check_val("t4_ready_back", {63'd0, in_ready}, 64'd1);

        // 5: reset mid-write with two words queued
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) push_word(30'h200 + 30'(i), 32'hB0 + 32'(i), 1'b1);
        check_val("t5_wen", {63'd0, mem_wen}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check_reset_values("t5_rst");
        @(posedge clk); #1;
        mem_stall = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        wc = wen_cycles;
        repeat (20) @(posedge clk);
        #1;
        check_val("t5_no_wen", 64'(wen_cycles - wc), 64'd0);
        check_val("t5_sent", {48'd0, sent_count}, 64'd0);
        check_val("t5_busy", {63'd0, busy}, 64'd0);

        // 6: CNT_W=2 wrap sequence
        for (int i = 0; i < 5; i++) begin
            push_word(30'd0, 32'h600 + 32'(i), 1'b1);
            drain();
            check_val("t6_cnt2_seq", {62'd0, sent_b}, {62'd0, seq[i]});
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
